// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode, bypass and EX-side signal bundle for the ID/EX operand stage
interface id_ex_operand_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4
);
  // decode slot
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [ALUOP_W-1:0]    id_alu_op;
  logic                  id_alu_src;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;

  // pipeline control
  logic                  flush;
  logic                  hold;

  // bypass sources
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [XLEN-1:0]       exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [XLEN-1:0]       memwb_result;

  // EX stage view
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic [XLEN-1:0]       ex_op_a;
  logic [XLEN-1:0]       ex_op_b;
  logic [XLEN-1:0]       ex_store_data;
  logic                  load_use_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           flush, hold,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, ex_pc, ex_rd, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_op_a, ex_op_b, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_alu_op, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           flush, hold,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, ex_pc, ex_rd, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_op_a, ex_op_b, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with EX operand forwarding and load-use bubble insertion
module id_ex_operand_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_operand_stage_if.slave  bus
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [ALUOP_W-1:0]    r_alu_op;
  logic                  r_alu_src;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;

  logic                  w_load_use_stall;
  logic [XLEN-1:0]       w_fwd_rs1;
  logic [XLEN-1:0]       w_fwd_rs2;

  // A load in EX whose destination feeds the decode slot cannot be bypassed in time.
  // hold and flush deliberately do not mask this; upstream redirect logic decides.
  assign w_load_use_stall = r_valid && r_mem_read && (r_rd != '0) && bus.id_valid &&
                            ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));

  // Pipeline register: flush > hold > load-use bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (bus.hold) begin
      r_valid      <= r_valid;
    end else if (w_load_use_stall) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_valid      <= bus.id_valid;
      r_pc         <= bus.id_pc;
      r_rs1_data   <= bus.id_rs1_data;
      r_rs2_data   <= bus.id_rs2_data;
      r_imm        <= bus.id_imm;
      r_rs1        <= bus.id_rs1;
      r_rs2        <= bus.id_rs2;
      r_rd         <= bus.id_rd;
      r_alu_op     <= bus.id_alu_op;
      r_alu_src    <= bus.id_alu_src;
      r_reg_write  <= bus.id_reg_write  & bus.id_valid;
      r_mem_read   <= bus.id_mem_read   & bus.id_valid;
      r_mem_write  <= bus.id_mem_write  & bus.id_valid;
      r_mem_to_reg <= bus.id_mem_to_reg & bus.id_valid;
    end
  end

  // Bypass selection; the younger EX/MEM result wins and x0 is never bypassed.
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    w_fwd_rs2 = r_rs2_data;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs1))
      w_fwd_rs1 = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs1))
      w_fwd_rs1 = bus.memwb_result;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs2))
      w_fwd_rs2 = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs2))
      w_fwd_rs2 = bus.memwb_result;
  end

  assign bus.ex_valid       = r_valid;
  assign bus.ex_pc          = r_pc;
  assign bus.ex_rd          = r_rd;
  assign bus.ex_alu_op      = r_alu_op;
  assign bus.ex_reg_write   = r_reg_write;
  assign bus.ex_mem_read    = r_mem_read;
  assign bus.ex_mem_write   = r_mem_write;
  assign bus.ex_mem_to_reg  = r_mem_to_reg;
  assign bus.ex_op_a        = w_fwd_rs1;
  assign bus.ex_op_b        = r_alu_src ? r_imm : w_fwd_rs2;
  assign bus.ex_store_data  = w_fwd_rs2;
  assign bus.load_use_stall = w_load_use_stall;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_operand_stage_if #(.XLEN(64), .REG_ADDR_W(5), .ALUOP_W(4)) bus ();

  id_ex_operand_stage #(.XLEN(64), .REG_ADDR_W(5), .ALUOP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a decoded instruction in the decode slot
  task automatic drive_id(input logic valid, input logic [63:0] pc,
                          input logic [4:0] rs1, input logic [63:0] rs1_data,
                          input logic [4:0] rs2, input logic [63:0] rs2_data,
                          input logic [4:0] rd, input logic [63:0] imm,
                          input logic alu_src, input logic reg_write, input logic mem_read);
    bus.id_valid      = valid;
    bus.id_pc         = pc;
    bus.id_rs1        = rs1;
    bus.id_rs1_data   = rs1_data;
    bus.id_rs2        = rs2;
    bus.id_rs2_data   = rs2_data;
    bus.id_rd         = rd;
    bus.id_imm        = imm;
    bus.id_alu_src    = alu_src;
    bus.id_reg_write  = reg_write;
    bus.id_mem_read   = mem_read;
    bus.id_mem_write  = 1'b0;
    bus.id_mem_to_reg = mem_read;
    bus.id_alu_op     = 4'h3;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_id(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    bus.exmem_reg_write = 1'b0; bus.exmem_rd = 5'd0; bus.exmem_result = 64'h0;
    bus.memwb_reg_write = 1'b0; bus.memwb_rd = 5'd0; bus.memwb_result = 64'h0;
    tick();
    tick();
    check("rst_valid", {63'h0, bus.ex_valid}, 64'h0);
    check("rst_pc", bus.ex_pc, 64'h0);
    check("rst_stall", {63'h0, bus.load_use_stall}, 64'h0);

    // first capture after release
    drive_id(1'b1, 64'h100, 5'd5, 64'h1, 5'd3, 64'h10, 5'd9, 64'h0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    check("cap_valid", {63'h0, bus.ex_valid}, 64'h1);
    check("cap_pc", bus.ex_pc, 64'h100);
    check("cap_rd", {59'h0, bus.ex_rd}, 64'd9);
    check("cap_aluop", {60'h0, bus.ex_alu_op}, 64'h3);
    check("cap_regwr", {63'h0, bus.ex_reg_write}, 64'h1);
    check("no_fwd_a", bus.ex_op_a, 64'h1);
    check("no_fwd_b", bus.ex_op_b, 64'h10);

    // hold the captured instruction while bypass inputs are exercised
    bus.hold = 1'b1;
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_result = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    check("fwd_exmem_a", bus.ex_op_a, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_result = 64'h7;
    #1;
    check("fwd_exmem_wins", bus.ex_op_a, 64'hFFFF_FFFF_FFFF_FFFE);
    bus.exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb_a", bus.ex_op_a, 64'h7);
    bus.memwb_rd = 5'd3; bus.memwb_result = 64'h42;
    #1;
    check("fwd_memwb_b", bus.ex_op_b, 64'h42);
    check("fwd_memwb_st", bus.ex_store_data, 64'h42);
    check("unfwd_a", bus.ex_op_a, 64'h1);
    bus.hold = 1'b0;

    // immediate path with rs2 still bypassed
    drive_id(1'b1, 64'h104, 5'd1, 64'h11, 5'd3, 64'h10, 5'd4, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1, 1'b0);
    tick();
    check("imm_b", bus.ex_op_b, 64'hFFFF_FFFF_FFFF_FFF0);
    check("imm_st", bus.ex_store_data, 64'h42);

    // x0 is never bypassed
    bus.memwb_reg_write = 1'b0;
    drive_id(1'b1, 64'h108, 5'd1, 64'h11, 5'd0, 64'h0, 5'd4, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 64'h99;
    #1;
    check("x0_b", bus.ex_op_b, 64'h0);
    bus.exmem_reg_write = 1'b0;

    // load-use on rs2
    drive_id(1'b1, 64'h10C, 5'd1, 64'h0, 5'd2, 64'h0, 5'd7, 64'h0, 1'b1, 1'b1, 1'b1);
    tick();
    check("ld_memrd", {63'h0, bus.ex_mem_read}, 64'h1);
    drive_id(1'b1, 64'h110, 5'd1, 64'h0, 5'd7, 64'h0, 5'd8, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
    check("lu_stall", {63'h0, bus.load_use_stall}, 64'h1);
    bus.id_valid = 1'b0;
    #1;
    check("lu_idinv", {63'h0, bus.load_use_stall}, 64'h0);
    bus.id_valid = 1'b1;
    tick();
    check("lu_bub_valid", {63'h0, bus.ex_valid}, 64'h0);
    check("lu_bub_regwr", {63'h0, bus.ex_reg_write}, 64'h0);
    check("lu_bub_stall", {63'h0, bus.load_use_stall}, 64'h0);

    // load to x0 never stalls
    drive_id(1'b1, 64'h114, 5'd1, 64'h0, 5'd2, 64'h0, 5'd0, 64'h0, 1'b1, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 64'h118, 5'd0, 64'h0, 5'd0, 64'h0, 5'd8, 64'h0, 1'b0, 1'b1, 1'b0);
    #1;
    check("lu_rd0", {63'h0, bus.load_use_stall}, 64'h0);

    // load-use under hold: registers unchanged
    drive_id(1'b1, 64'h200, 5'd1, 64'h0, 5'd2, 64'h0, 5'd7, 64'h0, 1'b1, 1'b1, 1'b1);
    tick();
    drive_id(1'b1, 64'h204, 5'd7, 64'h0, 5'd2, 64'h0, 5'd8, 64'h0, 1'b0, 1'b1, 1'b0);
    bus.hold = 1'b1;
    #1;
    check("hold_lu_stall", {63'h0, bus.load_use_stall}, 64'h1);
    tick();
    check("hold_lu_valid", {63'h0, bus.ex_valid}, 64'h1);
    check("hold_lu_pc", bus.ex_pc, 64'h200);

    // hold alone for three cycles
    drive_id(1'b1, 64'h300, 5'd1, 64'h0, 5'd2, 64'h0, 5'd8, 64'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc", bus.ex_pc, 64'h200);
      check("hold_memrd", {63'h0, bus.ex_mem_read}, 64'h1);
    end

    // flush beats hold
    bus.flush = 1'b1;
    tick();
    check("flush_valid", {63'h0, bus.ex_valid}, 64'h0);
    check("flush_memrd", {63'h0, bus.ex_mem_read}, 64'h0);
    check("flush_pc", bus.ex_pc, 64'h0);
    bus.flush = 1'b0;
    bus.hold  = 1'b0;

    // asynchronous reset mid-run
    drive_id(1'b1, 64'h400, 5'd1, 64'h5, 5'd2, 64'h6, 5'd10, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    check("pre_rst_valid", {63'h0, bus.ex_valid}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'h0, bus.ex_valid}, 64'h0);
    check("arst_pc", bus.ex_pc, 64'h0);
    check("arst_regwr", {63'h0, bus.ex_reg_write}, 64'h0);
    check("arst_op_a", bus.ex_op_a, 64'h0);
    drive_id(1'b1, 64'h100, 5'd1, 64'h0, 5'd2, 64'h0, 5'd3, 64'h0, 1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_valid", {63'h0, bus.ex_valid}, 64'h1);
    check("rel_pc", bus.ex_pc, 64'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
